qrisc32_id: RTL and testbench

Decode stage of the Qrisc32 five-stage pipeline. Consumes the fetched `instruction`/`pc` pair from the fetch stage and drives a registered, decoded micro-op to the EX stage. It owns the 32×32 register file, including the MEM write-back port with same-cycle bypass. It also detects load-use hazards and squashes wrong-path instructions after a taken jump.

---
 rtl/qrisc32_pkg.sv | 60 ++++++
 rtl/qrisc32_id_if.sv | 22 ++
 rtl/qrisc32_regfile.sv | 47 ++++
 rtl/qrisc32_id.sv | 129 ++++++++++++
 tb/tb_qrisc32_id.sv | 261 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/qrisc32_pkg.sv
// Shared types for the Qrisc32 decode stage.
// Defines micro-op codes, opcode field values and the decoded record.
package qrisc32_pkg;

    typedef enum logic [3:0] {
        OP_NOP,
        OP_LDR,
        OP_STR,
        OP_ADD,
        OP_SUB,
        OP_AND,
        OP_OR,
        OP_XOR,
        OP_SHL,
        OP_SHR,
        OP_ADDI,
        OP_JMP,
        OP_JMPR
    } op_t;

    localparam logic [5:0] OPC_LDR  = 6'd0;
    localparam logic [5:0] OPC_STR  = 6'd1;
    localparam logic [5:0] OPC_ADD  = 6'd2;
    localparam logic [5:0] OPC_SUB  = 6'd3;
    localparam logic [5:0] OPC_AND  = 6'd4;
    localparam logic [5:0] OPC_OR   = 6'd5;
    localparam logic [5:0] OPC_XOR  = 6'd6;
    localparam logic [5:0] OPC_SHL  = 6'd7;
    localparam logic [5:0] OPC_SHR  = 6'd8;
    localparam logic [5:0] OPC_ADDI = 6'd9;
    localparam logic [5:0] OPC_JMP  = 6'd10;
    localparam logic [5:0] OPC_JMPR = 6'd11;

    typedef struct packed {
        logic        valid;
        op_t         op;
        logic [4:0]  rd;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] imm;
        logic [31:0] pc;
        logic        illegal;
    } decoded_t;

    localparam decoded_t BUBBLE = '{
        valid:   1'b0,
        op:      OP_NOP,
        rd:      5'd0,
        a:       32'd0,
        b:       32'd0,
        imm:     32'd0,
        pc:      32'd0,
        illegal: 1'b0
    };

    function automatic logic [31:0] sext16(input logic [15:0] v);
        return {{16{v[15]}}, v};
    endfunction

endpackage

// File: rtl/qrisc32_id_if.sv
// Decoded micro-op bus from the ID stage to the EX stage.
// master drives the bus (ID), slave consumes it (EX or a bench).
interface qrisc32_id_if import qrisc32_pkg::*; ();

    logic        id_valid;
    op_t         id_op;
    logic [4:0]  id_rd;
    logic [31:0] id_a;
    logic [31:0] id_b;
    logic [31:0] id_imm;
    logic [31:0] id_pc;
    logic        id_illegal;

    modport master (
        output id_valid, id_op, id_rd, id_a, id_b, id_imm, id_pc, id_illegal
    );

    modport slave (
        input id_valid, id_op, id_rd, id_a, id_b, id_imm, id_pc, id_illegal
    );

endinterface

// File: rtl/qrisc32_regfile.sv
// General register file: two combinational read ports, one write port.
// R0 reads as zero; a same-cycle write-back is forwarded to both read ports.
module qrisc32_regfile #(
    parameter int unsigned NREGS = 32
) (
    input  logic        clk,
    input  logic [4:0]  i_ra_idx,
    input  logic [4:0]  i_rb_idx,
    output logic [31:0] o_ra_data,
    output logic [31:0] o_rb_data,
    input  logic        i_wb_en,
    input  logic [4:0]  i_wb_reg,
    input  logic [31:0] i_wb_data
);

    logic [31:0] r_regs [NREGS];
    logic        w_wr;

    assign w_wr = i_wb_en && (i_wb_reg != '0);

    always_ff @(posedge clk) begin
        if (w_wr) begin
            r_regs[i_wb_reg] <= i_wb_data;
        end
    end

    always_comb begin
        if (i_ra_idx == '0) begin
            o_ra_data = '0;
        end else if (w_wr && (i_wb_reg == i_ra_idx)) begin
            o_ra_data = i_wb_data;
        end else begin
            o_ra_data = r_regs[i_ra_idx];
        end
    end

    always_comb begin
        if (i_rb_idx == '0) begin
            o_rb_data = '0;
        end else if (w_wr && (i_wb_reg == i_rb_idx)) begin
            o_rb_data = i_wb_data;
        end else begin
            o_rb_data = r_regs[i_rb_idx];
        end
    end

endmodule

// File: rtl/qrisc32_id.sv
// Qrisc32 decode stage: register file, instruction decode, load-use stall
// detection and wrong-path squashing after a taken jump.
module qrisc32_id import qrisc32_pkg::*; #(
    parameter int unsigned NREGS       = 32,
    parameter int unsigned KILL_CYCLES = 2
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [31:0]  instruction,
    input  logic [31:0]  pc,
    input  logic         pipe_stall,
    input  logic         new_address_valid,
    input  logic         wb_en,
    input  logic [4:0]   wb_reg,
    input  logic [31:0]  wb_data,
    output logic         id_stall,
    qrisc32_id_if.master id_bus
);

    localparam int unsigned KW = (KILL_CYCLES > 0) ? $clog2(KILL_CYCLES + 1) : 1;

    logic [5:0]    w_opc;
    logic [4:0]    w_rd;
    logic [4:0]    w_ra;
    logic [4:0]    w_rb;
    logic [4:0]    w_rb_idx;
    logic [31:0]   w_imm;
    logic [31:0]   w_ra_data;
    logic [31:0]   w_rb_data;
    logic          w_reads_ra;
    logic          w_reads_rb;
    logic          w_hazard;
    logic          w_kill;
    decoded_t      w_dec;
    decoded_t      r_out;
    logic [KW-1:0] r_kill_cnt;

    assign w_opc    = instruction[31:26];
    assign w_rd     = instruction[25:21];
    assign w_ra     = instruction[20:16];
    assign w_rb     = instruction[15:11];
    assign w_imm    = sext16(instruction[15:0]);
    assign w_rb_idx = (w_opc == OPC_STR) ? w_rd : w_rb;

    qrisc32_regfile #(
        .NREGS (NREGS)
    ) u_regfile (
        .clk       (clk),
        .i_ra_idx  (w_ra),
        .i_rb_idx  (w_rb_idx),
        .o_ra_data (w_ra_data),
        .o_rb_data (w_rb_data),
        .i_wb_en   (wb_en),
        .i_wb_reg  (wb_reg),
        .i_wb_data (w_wb_data_unused_guard(wb_data))
    );

    function automatic logic [31:0] w_wb_data_unused_guard(input logic [31:0] v);
        return v;
    endfunction

    always_comb begin
        w_dec         = BUBBLE;
        w_reads_ra    = 1'b0;
        w_reads_rb    = 1'b0;
        w_dec.valid   = 1'b1;
        w_dec.pc      = pc;
        w_dec.rd      = w_rd;
        w_dec.imm     = w_imm;
        // Legal opcodes 0..11 map one-to-one onto op_t codes 1..12.
        w_dec.op      = op_t'(w_opc[3:0] + 4'd1);
        case (w_opc)
            OPC_LDR, OPC_ADDI: begin
                w_dec.a    = w_ra_data;
                w_dec.b    = w_imm;
                w_reads_ra = 1'b1;
            end
            OPC_STR, OPC_ADD, OPC_SUB, OPC_AND, OPC_OR, OPC_XOR, OPC_SHL, OPC_SHR: begin
                w_dec.a    = w_ra_data;
                w_dec.b    = w_rb_data;
                w_reads_ra = 1'b1;
                w_reads_rb = 1'b1;
            end
            OPC_JMP: begin
                w_dec.b    = w_imm;
            end
            OPC_JMPR: begin
                w_dec.a    = w_ra_data;
                w_reads_ra = 1'b1;
            end
            default: begin
                w_dec.op      = OP_NOP;
                w_dec.rd      = '0;
                w_dec.imm     = '0;
                w_dec.illegal = 1'b1;
            end
        endcase
    end

    assign w_hazard = r_out.valid && (r_out.op == OP_LDR) && (r_out.rd != '0) &&
                      ((w_reads_ra && (w_ra == r_out.rd)) ||
                       (w_reads_rb && (w_rb_idx == r_out.rd)));
    assign w_kill   = new_address_valid || (r_kill_cnt != '0);
    assign id_stall = w_hazard && !w_kill;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_out      <= BUBBLE;
            r_kill_cnt <= '0;
        end else if (!pipe_stall) begin
            r_out <= (w_kill || w_hazard) ? BUBBLE : w_dec;
            if (new_address_valid) begin
                r_kill_cnt <= KW'(KILL_CYCLES);
            end else if (r_kill_cnt != '0) begin
                r_kill_cnt <= r_kill_cnt - 1'b1;
            end
        end
    end

    assign id_bus.id_valid   = r_out.valid;
    assign id_bus.id_op      = r_out.op;
    assign id_bus.id_rd      = r_out.rd;
    assign id_bus.id_a       = r_out.a;
    assign id_bus.id_b       = r_out.b;
    assign id_bus.id_imm     = r_out.imm;
    assign id_bus.id_pc      = r_out.pc;
    assign id_bus.id_illegal = r_out.illegal;

endmodule

// File: tb/tb_qrisc32_id.sv
// Randomized bench for qrisc32_id against a table-driven pipeline model,
// preceded by directed reset, bypass, load-use, flush, stall and illegal cases.
module tb_qrisc32_id;
    import qrisc32_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] instruction;
    logic [31:0] pc;
    logic        pipe_stall;
    logic        new_address_valid;
    logic        wb_en;
    logic [4:0]  wb_reg;
    logic [31:0] wb_data;
    logic        id_stall;

    qrisc32_id_if bus ();

    qrisc32_id #(
        .NREGS       (32),
        .KILL_CYCLES (2)
    ) dut (
        .clk               (clk),
        .reset             (reset),
        .instruction       (instruction),
        .pc                (pc),
        .pipe_stall        (pipe_stall),
        .new_address_valid (new_address_valid),
        .wb_en             (wb_en),
        .wb_reg            (wb_reg),
        .wb_data           (wb_data),
        .id_stall          (id_stall),
        .id_bus            (bus)
    );

    always #5 clk = ~clk;

    int          n_vec = 0;
    int          n_err = 0;
    logic [31:0] mreg [32];
    decoded_t    e_out;
    int          e_kill;
    bit          exp_stall;
    logic        obs_stall;
    op_t         optab [12] = '{OP_LDR, OP_STR, OP_ADD, OP_SUB, OP_AND, OP_OR,
                                OP_XOR, OP_SHL, OP_SHR, OP_ADDI, OP_JMP, OP_JMPR};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, want %h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [31:0] m_read(input logic [4:0] idx, input logic wen,
                                           input logic [4:0] wr, input logic [31:0] wd);
        if (idx == 0) return 32'd0;
        if (wen && wr == idx) return wd;
        return mreg[idx];
    endfunction

    function automatic decoded_t m_decode(input logic [31:0] ins, input logic [31:0] p,
                                          input logic wen, input logic [4:0] wr,
                                          input logic [31:0] wd);
        decoded_t    d;
        int          opc;
        logic [31:0] imm;
        logic [31:0] ra_v;
        d    = '0;
        opc  = int'(ins[31:26]);
        imm  = 32'($signed(ins[15:0]));
        ra_v = m_read(ins[20:16], wen, wr, wd);
        d.valid = 1'b1;
        d.pc    = p;
        if (opc > 11) begin
            d.illegal = 1'b1;
            return d;
        end
        d.op  = optab[opc];
        d.rd  = ins[25:21];
        d.imm = imm;
        if (opc == 0 || opc == 9) begin
            d.a = ra_v; d.b = imm;
        end else if (opc == 1) begin
            d.a = ra_v; d.b = m_read(ins[25:21], wen, wr, wd);
        end else if (opc <= 8) begin
            d.a = ra_v; d.b = m_read(ins[15:11], wen, wr, wd);
        end else if (opc == 10) begin
            d.b = imm;
        end else begin
            d.a = ra_v;
        end
        return d;
    endfunction

    function automatic bit m_reads(input logic [31:0] ins, input logic [4:0] r);
        int opc;
        opc = int'(ins[31:26]);
        if (opc == 0 || opc == 9 || opc == 11) return ins[20:16] == r;
        if (opc == 1) return ins[20:16] == r || ins[25:21] == r;
        if (opc >= 2 && opc <= 8) return ins[20:16] == r || ins[15:11] == r;
        return 1'b0;
    endfunction

    task automatic check_outputs();
        chk("id_valid",   bus.id_valid,   e_out.valid);
        chk("id_op",      bus.id_op,      e_out.op);
        chk("id_rd",      bus.id_rd,      e_out.rd);
        chk("id_a",       bus.id_a,       e_out.a);
        chk("id_b",       bus.id_b,       e_out.b);
        chk("id_imm",     bus.id_imm,     e_out.imm);
        chk("id_pc",      bus.id_pc,      e_out.pc);
        chk("id_illegal", bus.id_illegal, e_out.illegal);
    endtask

    task automatic cycle(input logic [31:0] ins, input logic [31:0] p, input logic ps,
                         input logic nav, input logic wen, input logic [4:0] wr,
                         input logic [31:0] wd);
        decoded_t d;
        bit       hz;
        bit       kl;
        @(negedge clk);
        reset = 1'b0; instruction = ins; pc = p; pipe_stall = ps;
        new_address_valid = nav; wb_en = wen; wb_reg = wr; wb_data = wd;
        d  = m_decode(ins, p, wen, wr, wd);
        hz = e_out.valid && e_out.op == OP_LDR && e_out.rd != 0 && m_reads(ins, e_out.rd);
        kl = nav || (e_kill != 0);
        exp_stall = hz && !kl;
        #1;
        obs_stall = id_stall;
        chk("id_stall", id_stall, exp_stall);
        if (!ps) begin
            e_out = (kl || hz) ? decoded_t'('0) : d;
            if (nav) e_kill = 2;
            else if (e_kill > 0) e_kill--;
        end
        if (wen && wr != 0) mreg[wr] = wd;
        @(posedge clk);
        #1;
        check_outputs();
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1; instruction = '0; pc = '0; pipe_stall = 1'b0;
        new_address_valid = 1'b0; wb_en = 1'b0; wb_reg = '0; wb_data = '0;
        repeat (2) @(posedge clk);
        #1;
        e_out  = '0;
        e_kill = 0;
        check_outputs();
        chk("rst_id_stall", id_stall, 1'b0);
    endtask

    function automatic logic [31:0] rand_ins();
        logic [31:0] w;
        w = $urandom;
        w[31:26] = ($urandom_range(99) < 85) ? 6'($urandom_range(11)) : 6'($urandom_range(63));
        w[25:21] = 5'($urandom_range(7));
        w[20:16] = 5'($urandom_range(7));
        w[15:11] = 5'($urandom_range(7));
        return w;
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout, want completion");
        $fatal(1);
    end

    initial begin
        logic [31:0] cur_ins;
        logic [31:0] cur_pc;
        bit          hold;
        int          nb;
        logic        ps;
        logic        nav;

        for (int i = 0; i < 32; i++) mreg[i] = '0;
        e_out  = '0;
        e_kill = 0;

        do_reset();
        for (int r = 1; r < 32; r++) cycle(32'h0, 32'h0, 1'b0, 1'b0, 1'b1, 5'(r), $urandom);

        // ADD R1,R3,R0 with a same-cycle write-back to R3
        cycle(32'h0823_0000, 32'h10, 1'b0, 1'b0, 1'b1, 5'd3, 32'h1234);
        chk("wb_bypass_a",  bus.id_a, 32'h1234);
        chk("wb_bypass_b",  bus.id_b, 32'h0);
        chk("wb_bypass_op", bus.id_op, OP_ADD);
        chk("wb_bypass_rd", bus.id_rd, 32'd1);

        // LDR R2,[R0+4] ; ADD R4,R2,R2
        cycle(32'h0040_0004, 32'h14, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0);
        cycle(32'h0882_1000, 32'h18, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0);
        chk("lu_stall",  obs_stall, 1'b1);
        chk("lu_bubble", bus.id_valid, 1'b0);
        cycle(32'h0882_1000, 32'h18, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0);
        chk("lu_stall_clear", obs_stall, 1'b0);
        chk("lu_add_op", bus.id_op, OP_ADD);
        chk("lu_add_rd", bus.id_rd, 32'd4);

        // Flush with three words in flight
        nb = 0;
        for (int k = 0; k < 3; k++) begin
            cycle(32'h24A1_0007, 32'h20 + 32'(4 * k), 1'b0, k == 0, 1'b0, 5'd0, 32'h0);
            if (!bus.id_valid) nb++;
        end
        chk("flush_bubbles", nb, 3);
        cycle(32'h24A1_0007, 32'h2C, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0);
        chk("flush_resume", bus.id_valid, 1'b1);

        // pipe_stall hold for three cycles
        cycle(32'h24A1_0001, 32'h100, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0);
        for (int k = 0; k < 3; k++) begin
            cycle(32'h24A1_0002, 32'h104, 1'b1, 1'b0, 1'b0, 5'd0, 32'h0);
            chk("stall_hold_pc", bus.id_pc, 32'h100);
        end
        cycle(32'h24A1_0002, 32'h104, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0);
        chk("stall_next_pc", bus.id_pc, 32'h104);
        cycle(32'h24A1_0003, 32'h108, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0);
        chk("stall_after_pc", bus.id_pc, 32'h108);

        // Illegal opcode
        cycle(32'hFC00_0000, 32'h40, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0);
        chk("ill_valid", bus.id_valid, 1'b1);
        chk("ill_op",    bus.id_op, OP_NOP);
        chk("ill_flag",  bus.id_illegal, 1'b1);
        chk("ill_pc",    bus.id_pc, 32'h40);

        // Random stream; the bench acts as fetch and holds the word while stalled
        cur_ins = rand_ins();
        cur_pc  = 32'h1000;
        hold    = 1'b0;
        for (int n = 0; n < 600; n++) begin
            if (!hold) begin
                cur_ins = rand_ins();
                cur_pc  = cur_pc + 32'd4;
            end
            ps  = ($urandom_range(9) == 0);
            nav = ($urandom_range(11) == 0);
            cycle(cur_ins, cur_pc, ps, nav, 1'($urandom_range(1)), 5'($urandom_range(31)), $urandom);
            hold = ps || exp_stall;
            if (nav && !ps) begin
                cur_pc = {$urandom_range(255), 2'b00};
                hold   = 1'b0;
            end
        end

        // Reset mid-flush must clear the kill counter
        cycle(32'h24A1_0005, 32'h200, 1'b0, 1'b1, 1'b0, 5'd0, 32'h0);
        do_reset();
        cycle(32'h24A1_0006, 32'h204, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0);
        chk("rst_kill_clear", bus.id_valid, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
